// File: rtl/btn_pkg.sv
// Shared constants for the game-control button front-end: channel indices,
// default timing and the auto-repeat state type (used when AUTOREPEAT_EN is defined).
package btn_pkg;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_ROTATE = 2;
    localparam int BTN_FAST   = 3;
    localparam int BTN_PAUSE  = 4;

    localparam int NUM_BTN_DEF      = 5;
    localparam int DEBOUNCE_CYC_DEF = 20000;
    localparam int REPEAT_DELAY_DEF = 2000000;
    localparam int REPEAT_RATE_DEF  = 800000;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, polarity normalise, debounce, press-edge pulse.
// Optional hold-to-repeat timer is built only when AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int   DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter logic ACTIVE_LOW   = 1'b1,
    parameter logic REPEAT_EN    = 1'b0,
    parameter int   REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int   REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_evt
);

    localparam int            CW       = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_evt;
    logic          w_s;
    logic          w_rise;
    logic          w_fire;

    assign w_s    = r_sync2 ^ ACTIVE_LOW;
    assign w_rise = r_level & ~r_level_d;

    // Synchronisers reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= ACTIVE_LOW;
            r_sync2   <= ACTIVE_LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int            TMAX     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            TW       = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

    rpt_state_t    r_state;
    logic [TW-1:0] r_tmr;

    always_ff @(posedge i_clk) begin
        if (i_reset || !REPEAT_EN || !r_level) begin
            r_state <= IDLE;
            r_tmr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= DELAY;
                        r_tmr   <= '0;
                    end
                end
                DELAY: begin
                    if (r_tmr == DLY_LAST) begin
                        r_state <= REPEAT;
                        r_tmr   <= '0;
                    end else if (r_tmr != '1) begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                REPEAT: begin
                    if (r_tmr == RATE_LAST) r_tmr <= '0;
                    else if (r_tmr != '1)   r_tmr <= r_tmr + 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_tmr   <= '0;
                end
            endcase
        end
    end

    assign w_fire = REPEAT_EN && r_level &&
                    (((r_state == DELAY)  && (r_tmr == DLY_LAST)) ||
                     ((r_state == REPEAT) && (r_tmr == RATE_LAST)));
`else
    assign w_fire = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) r_evt <= 1'b0;
        else         r_evt <= w_rise | w_fire;
    end

    assign o_level = r_level;
    assign o_evt   = r_evt;

endmodule

// File: rtl/btn_conditioner.sv
// Game-control button front-end: per-channel debounce plus sticky press flags
// cleared by the game core's step tick. Define AUTOREPEAT_EN for hold-to-repeat.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int                 NUM_BTN      = NUM_BTN_DEF,
    parameter int                 DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW   = NUM_BTN'(5'b11),
    parameter logic [NUM_BTN-1:0] REPEAT_MASK  = NUM_BTN'(5'b11),
    parameter int                 REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int                 REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    input  logic               i_consume,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_press_pend,
    output logic [NUM_BTN-1:0] o_press_evt
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_evt;
    logic [NUM_BTN-1:0] r_pend;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW[g]),
            .REPEAT_EN    (REPEAT_MASK[g]),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_raw   (i_btn_raw[g]),
            .o_level (w_level[g]),
            .o_evt   (w_evt[g])
        );
    end

    // A new event in the consume cycle wins, so a short press is never dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_pend <= '0;
        else         r_pend <= (r_pend & ~{NUM_BTN{i_consume}}) | w_evt;
    end

    assign o_btn_level  = w_level;
    assign o_press_evt  = w_evt;
    assign o_press_pend = r_pend;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed steps plus random pin activity,
// compared every cycle against a sample-window reference model.
module tb_btn_conditioner;

    localparam int         N  = 5;
    localparam int         D  = 4;
    localparam int         RD = 10;
    localparam int         RR = 3;
    localparam logic [4:0] AL = 5'b11111;
    localparam logic [4:0] RM = 5'b00011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       consume = 1'b0;
    logic [4:0] btn_raw = 5'h00;
    logic [4:0] btn_level;
    logic [4:0] press_pend;
    logic [4:0] press_evt;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .NUM_BTN      (N),
        .DEBOUNCE_CYC (D),
        .ACTIVE_LOW   (AL),
        .REPEAT_MASK  (RM),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_btn_raw    (btn_raw),
        .i_consume    (consume),
        .o_btn_level  (btn_level),
        .o_press_pend (press_pend),
        .o_press_evt  (press_evt)
    );

    always #5 clk = ~clk;

    // Reference model: level flips once the last D synchronised samples all disagree
    // with it; events come from edges-since-press arithmetic.
    logic [D+1:0] m_hist [N];
    logic [4:0]   m_lvl  = '0;
    logic [4:0]   m_evt  = '0;
    logic [4:0]   m_pend = '0;
    int           m_held [N];
    logic [4:0]   al_v = AL;
    logic [4:0]   rm_v = RM;

    function automatic logic rep_en(int i);
`ifdef AUTOREPEAT_EN
        return rm_v[i];
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        logic [4:0] nxt_evt;
        logic       tog;
        int         h;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_hist[i] = '0;
                m_held[i] = -1;
            end
            m_lvl  = '0;
            m_evt  = '0;
            m_pend = '0;
        end else begin
            m_pend  = (m_pend & ~{5{consume}}) | m_evt;
            nxt_evt = '0;
            for (int i = 0; i < N; i++) begin
                if (m_lvl[i] && m_held[i] >= 0) begin
                    h = m_held[i];
                    nxt_evt[i] = (h == 0) || (rep_en(i) && h >= RD && ((h - RD) % RR) == 0);
                end
                m_hist[i] = {m_hist[i][D:0], btn_raw[i] ^ al_v[i]};
                tog = (m_hist[i][D+1:2] == {D{~m_lvl[i]}});
                if (tog) m_lvl[i] = ~m_lvl[i];
                if (!m_lvl[i])  m_held[i] = -1;
                else if (tog)   m_held[i] = 0;
                else            m_held[i] = m_held[i] + 1;
            end
            m_evt = nxt_evt;
        end
    end

    task automatic chk(string tag, logic [4:0] got, logic [4:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(string tag, int got, int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("level", btn_level, m_lvl);
        chk("evt", press_evt, m_evt);
        chk("pend", press_pend, m_pend);
    endtask

    initial begin
        logic [4:0] acc;
        int         n_evt;
        int         first;
        int         n4;
        int         q_got[$];
        int         q_exp[$];

        // 1: reset with all pins pressed
        repeat (3) tick();
        chk("rst_level", btn_level, 5'h00);
        chk("rst_evt", press_evt, 5'h00);
        chk("rst_pend", press_pend, 5'h00);
        reset = 1'b0;
        repeat (5) tick();
        chk("t1_level_c5", btn_level, 5'h00);
        tick();
        chk("t1_level_c6", btn_level, 5'h1F);
        tick();
        chk("t1_evt_c7", press_evt, 5'h1F);
        tick();
        chk("t1_pend_c8", press_pend, 5'h1F);
        btn_raw = 5'h1F;
        consume = 1'b1;
        tick();
        consume = 1'b0;
        chk("t1_pend_cleared", press_pend, 5'h00);
        repeat (12) tick();

        // 2: 3-cycle glitch on channel 0
        acc = '0;
        btn_raw[0] = 1'b0;
        repeat (3) begin tick(); acc = acc | btn_level | press_evt | press_pend; end
        btn_raw[0] = 1'b1;
        repeat (10) begin tick(); acc = acc | btn_level | press_evt | press_pend; end
        chk("t2_glitch", acc & 5'h01, 5'h00);

        // 3: channel 2 held for 20 cycles
        n_evt = 0;
        first = -1;
        btn_raw[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5) chk("t3_level_c5", btn_level & 5'h04, 5'h00);
            if (k == 6) chk("t3_level_c6", btn_level & 5'h04, 5'h04);
            if (press_evt[2]) begin
                n_evt++;
                if (first < 0) first = k;
            end
        end
        chk("t3_pend_held", press_pend & 5'h04, 5'h04);
        consume = 1'b1;
        tick();
        consume = 1'b0;
        chk("t3_pend_consumed", press_pend & 5'h04, 5'h00);
        btn_raw[2] = 1'b1;
        repeat (12) begin tick(); if (press_evt[2]) n_evt++; end
        chk_int("t3_evt_count", n_evt, 1);
        chk_int("t3_evt_cycle", first, 7);
        chk("t3_pend_release", press_pend & 5'h04, 5'h00);

        // 4: event coincident with consume
        btn_raw[1] = 1'b0;
        repeat (7) tick();
        chk("t4_evt_c7", press_evt & 5'h02, 5'h02);
        consume = 1'b1;
        tick();
        chk("t4_pend_wins", press_pend & 5'h02, 5'h02);
        tick();
        consume = 1'b0;
        chk("t4_pend_clear", press_pend & 5'h02, 5'h00);
        btn_raw[1] = 1'b1;
        repeat (12) tick();

        // 5: channels 0 (repeat-capable) and 4 (no repeat) held 30 cycles
        n4 = 0;
        btn_raw[0] = 1'b0;
        btn_raw[4] = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            if (k == 31) begin
                btn_raw[0] = 1'b1;
                btn_raw[4] = 1'b1;
            end
            tick();
            if (press_evt[0]) q_got.push_back(k);
            if (press_evt[4]) n4++;
        end
`ifdef AUTOREPEAT_EN
        q_exp = '{7, 17, 20, 23, 26, 29, 32, 35};
`else
        q_exp = '{7};
`endif
        chk_int("t5_ch0_count", q_got.size(), q_exp.size());
        for (int j = 0; j < q_exp.size() && j < q_got.size(); j++)
            chk_int("t5_ch0_cycle", q_got[j], q_exp[j]);
        chk_int("t5_ch4_count", n4, 1);
        consume = 1'b1;
        tick();
        consume = 1'b0;

        // 6: reset during a partial debounce count
        btn_raw[3] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("t6_in_reset", btn_level, 5'h00);
        reset = 1'b0;
        repeat (5) tick();
        chk("t6_level_c5", btn_level & 5'h08, 5'h00);
        tick();
        chk("t6_level_c6", btn_level & 5'h08, 5'h08);
        btn_raw[3] = 1'b1;
        repeat (12) tick();

        // random pin activity, step ticks and occasional reset
        for (int k = 0; k < 70; k++) begin
            int dur;
            btn_raw = 5'($urandom);
            dur = $urandom_range(1, 30);
            for (int j = 0; j < dur; j++) begin
                consume = ($urandom_range(0, 5) == 0);
                reset   = ($urandom_range(0, 150) == 0);
                tick();
            end
        end
        reset = 1'b0;
        consume = 1'b0;
        btn_raw = 5'h1F;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
